// File: rtl/ecc_write_scheduler_pkg.sv
// ecc_write_scheduler_pkg
// Shared definitions for the ECC write scheduler: the port index constants
// carried on m_src, the injection FSM state encoding, and the widths of the
// raw and encoded data words.
package ecc_write_scheduler_pkg;

  localparam int DATA_W     = 64;
  localparam int CODE_W     = 72;
  localparam int PARITY_BIT = 64;

  localparam logic SRC_HOST  = 1'b0;
  localparam logic SRC_SCRUB = 1'b1;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

endpackage

// File: rtl/ECCEncoder.sv
// ECCEncoder
// Builds the 72-bit stored word from 64 data bits: the data passes through
// unchanged, bit 64 holds the even parity of the data, and bits 71:65 are zero.
// Ports:
//   data  in   64  raw data word
//   code  out  72  encoded word
module ECCEncoder
  import ecc_write_scheduler_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  assign code = {{(CODE_W - DATA_W - 1){1'b0}}, ^data, data};

endmodule

// File: rtl/ecc_write_scheduler.sv
// ecc_write_scheduler
// Merges host and scrub write requests into one stream of ECC-encoded words
// toward memory. A round-robin arbiter picks one port per cycle, the winning
// word is encoded and captured in a single output register slot, and a
// one-shot injector can flip the parity bit of the next accepted word.
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   h_valid/h_ready          host request handshake, with h_addr[AW], h_data[64]
//   s_valid/s_ready          scrub request handshake, with s_addr[AW], s_data[64]
//   m_valid/m_ready          output handshake toward memory
//   m_addr, m_data, m_src    registered address, encoded word [72], winning port
//   inj_arm, inj_pending     arm pulse / armed status of the parity-error injector
//   word_count               saturating count of accepted words [32]
module ecc_write_scheduler
  import ecc_write_scheduler_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [AW-1:0]     h_addr,
  input  logic [DATA_W-1:0] h_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [AW-1:0]     s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [AW-1:0]     m_addr,
  output logic [CODE_W-1:0] m_data,
  output logic              m_src,
  input  logic              inj_arm,
  output logic              inj_pending,
  output logic [31:0]       word_count
);

  logic              last_grant;
  logic              grant;
  logic              slot_free;
  logic              xfer;
  logic              corrupt;
  logic [AW-1:0]     win_addr;
  logic [DATA_W-1:0] win_data;
  logic [CODE_W-1:0] raw_code;
  logic [CODE_W-1:0] store_code;
  logic [31:0]       word_count_r;
  inj_state_e        inj_state, inj_state_next;

  // The slot can take a word when it is empty or being drained this cycle.
  assign slot_free = ~m_valid | m_ready;

  // A lone requester always wins; on a tie the port that did not win last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = SRC_HOST;
    if (h_valid && s_valid) grant = ~last_grant;
    else if (s_valid)       grant = SRC_SCRUB;
  end

  // Reset is folded in so neither port sees ready while the block is held.
  assign h_ready = ~sys_rst & slot_free & (grant == SRC_HOST)  & h_valid;
  assign s_ready = ~sys_rst & slot_free & (grant == SRC_SCRUB) & s_valid;
  assign xfer    = h_ready | s_ready;

  assign win_addr = (grant == SRC_SCRUB) ? s_addr : h_addr;
  assign win_data = (grant == SRC_SCRUB) ? s_data : h_data;

  ECCEncoder u_encoder (
    .data (win_data),
    .code (raw_code)
  );

  always_comb begin
    store_code             = raw_code;
    store_code[PARITY_BIT] = raw_code[PARITY_BIT] ^ corrupt;
  end

  // Injection FSM: state register.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (sys_rst) inj_state <= INJ_IDLE;
    else         inj_state <= inj_state_next;
  end

  // Injection FSM: next state. An arm that coincides with a transfer in
  // INJ_IDLE leaves the current word intact and applies to the next one.
  always_comb begin
    inj_state_next = inj_state;
    unique case (inj_state)
      INJ_IDLE:  if (inj_arm) inj_state_next = INJ_ARMED;
      INJ_ARMED: if (xfer)    inj_state_next = INJ_IDLE;
      default:                inj_state_next = INJ_IDLE;
    endcase
  end

  // Injection FSM: outputs.
  always_comb begin
    inj_pending = (inj_state == INJ_ARMED);
    corrupt     = (inj_state == INJ_ARMED) & xfer;
  end

  // Output slot and round-robin history. Reset drops a held word outright.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      m_valid    <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      m_src      <= SRC_HOST;
      last_grant <= SRC_SCRUB;
    end else if (xfer) begin
      m_valid    <= 1'b1;
      m_addr     <= win_addr;
      m_data     <= store_code;
      m_src      <= grant;
      last_grant <= grant;
    end else if (m_ready) begin
      m_valid    <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                          word_count_r <= '0;
    else if (xfer && (word_count_r != '1)) word_count_r <= word_count_r + 32'd1;
  end

  assign word_count = word_count_r;

endmodule

// File: tb/tb_ecc_write_scheduler.sv
// tb_ecc_write_scheduler
// Directed bench for ecc_write_scheduler: reset state, single-port transfer,
// round-robin alternation, backpressure hold, parity injection, reset while a
// word is held, and word_count saturation.
module tb_ecc_write_scheduler;

  localparam int AW = 24;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          h_valid = 1'b0;
  logic          h_ready;
  logic [AW-1:0] h_addr  = '0;
  logic [63:0]   h_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] s_addr  = '0;
  logic [63:0]   s_data  = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] m_addr;
  logic [71:0]   m_data;
  logic          m_src;
  logic          inj_arm = 1'b0;
  logic          inj_pending;
  logic [31:0]   word_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  ecc_write_scheduler #(.AW(AW)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .h_valid     (h_valid),
    .h_ready     (h_ready),
    .h_addr      (h_addr),
    .h_data      (h_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_addr      (s_addr),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_src       (m_src),
    .inj_arm     (inj_arm),
    .inj_pending (inj_pending),
    .word_count  (word_count)
  );

  // Inputs change just after a falling edge; outputs are sampled 1 time unit
  // later (combinational readies) or 1 time unit after the rising edge.
  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1; h_valid = 1'b0; s_valid = 1'b0; inj_arm = 1'b0; m_ready = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1; h_valid = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    vectors++;
    if ({h_ready, s_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 00", {h_ready, s_ready});
    end
    @(posedge sys_clk); #1;
    vectors++;
    if ({m_valid, m_src, inj_pending} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000", {m_valid, m_src, inj_pending});
    end
    vectors++;
    if (m_data !== 72'h0 || m_addr !== 24'h0) begin
      miscompares++; $display("FAIL reset_word: got %h/%h expected 0/0", m_addr, m_data);
    end
    vectors++;
    if (word_count !== 32'h0) begin
      miscompares++; $display("FAIL reset_count: got %h expected 0", word_count);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0; h_valid = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_host_only();
    @(negedge sys_clk);
    m_ready = 1'b1; h_valid = 1'b1; h_addr = 24'h10; h_data = 64'h1;
    #1;
    vectors++;
    if ({h_ready, s_ready} !== 2'b10) begin
      miscompares++; $display("FAIL host_ready: got %b expected 10", {h_ready, s_ready});
    end
    @(posedge sys_clk); #1;
    vectors++;
    if (m_valid !== 1'b1 || m_src !== 1'b0 || m_addr !== 24'h10) begin
      miscompares++; $display("FAIL host_out: got v=%b src=%b addr=%h expected 1/0/10", m_valid, m_src, m_addr);
    end
    vectors++;
    if (m_data !== 72'h01_0000000000000001) begin
      miscompares++; $display("FAIL host_data: got %h expected 010000000000000001", m_data);
    end
    vectors++;
    if (word_count !== 32'd1) begin
      miscompares++; $display("FAIL host_count: got %0d expected 1", word_count);
    end
    @(negedge sys_clk);
    h_valid = 1'b0;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++; $display("FAIL host_drain: m_valid got %b expected 0", m_valid);
    end
  endtask

  // Host word 0x3 has even parity; scrub word 0x8000... has odd parity.
  task automatic test_round_robin();
    logic        exp_src;
    logic [71:0] exp_data;
    do_reset();
    @(negedge sys_clk);
    m_ready = 1'b1;
    h_valid = 1'b1; h_addr = 24'h100; h_data = 64'h3;
    s_valid = 1'b1; s_addr = 24'h200; s_data = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 4; i++) begin
      exp_src  = (i % 2 == 1);
      exp_data = exp_src ? 72'h01_8000000000000000 : 72'h00_0000000000000003;
      #1;
      vectors++;
      if ({h_ready, s_ready} !== {~exp_src, exp_src}) begin
        miscompares++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, {h_ready, s_ready}, {~exp_src, exp_src});
      end
      @(posedge sys_clk); #1;
      vectors++;
      if (m_valid !== 1'b1 || m_src !== exp_src || m_data !== exp_data) begin
        miscompares++;
        $display("FAIL rr_out[%0d]: got v=%b src=%b data=%h expected 1/%b/%h", i, m_valid, m_src, m_data, exp_src, exp_data);
      end
      @(negedge sys_clk);
    end
    vectors++;
    if (word_count !== 32'd4) begin
      miscompares++; $display("FAIL rr_count: got %0d expected 4", word_count);
    end
  endtask

  // Continues from the round-robin run: slot holds the scrub word, host is next.
  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({h_ready, s_ready} !== 2'b00) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, {h_ready, s_ready});
      end
      @(posedge sys_clk); #1;
      vectors++;
      if (m_valid !== 1'b1 || m_addr !== 24'h200 || m_data !== 72'h01_8000000000000000 || word_count !== 32'd4) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b addr=%h data=%h cnt=%0d expected 1/200/018000000000000000/4", i, m_valid, m_addr, m_data, word_count);
      end
      @(negedge sys_clk);
    end
    m_ready = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_src !== 1'b0 || m_addr !== 24'h100 || word_count !== 32'd5) begin
      miscompares++; $display("FAIL bp_resume: got src=%b addr=%h cnt=%0d expected 0/100/5", m_src, m_addr, word_count);
    end
    @(negedge sys_clk);
    h_valid = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_inject();
    @(negedge sys_clk);
    m_ready = 1'b1; inj_arm = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (inj_pending !== 1'b1) begin
      miscompares++; $display("FAIL inj_armed: got %b expected 1", inj_pending);
    end
    @(negedge sys_clk);
    inj_arm = 1'b0; s_valid = 1'b1; s_addr = 24'h20; s_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_data !== 72'h01_FFFFFFFFFFFFFFFF || m_src !== 1'b1 || inj_pending !== 1'b0) begin
      miscompares++; $display("FAIL inj_word: got data=%h src=%b pend=%b expected 01FFFFFFFFFFFFFFFF/1/0", m_data, m_src, inj_pending);
    end
    @(negedge sys_clk);
    s_addr = 24'h21;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_data !== 72'h00_FFFFFFFFFFFFFFFF || m_addr !== 24'h21) begin
      miscompares++; $display("FAIL inj_next: got %h/%h expected 21/00FFFFFFFFFFFFFFFF", m_addr, m_data);
    end
    // Arm coinciding with a transfer: this word is clean, the next is flipped.
    @(negedge sys_clk);
    s_valid = 1'b0; h_valid = 1'b1; h_addr = 24'h30; h_data = 64'h1; inj_arm = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_data !== 72'h01_0000000000000001 || inj_pending !== 1'b1) begin
      miscompares++; $display("FAIL inj_coincide: got data=%h pend=%b expected 010000000000000001/1", m_data, inj_pending);
    end
    @(negedge sys_clk);
    inj_arm = 1'b0; h_addr = 24'h31;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_data !== 72'h00_0000000000000001 || inj_pending !== 1'b0) begin
      miscompares++; $display("FAIL inj_following: got data=%h pend=%b expected 000000000000000001/0", m_data, inj_pending);
    end
    @(negedge sys_clk);
    h_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge sys_clk);
    m_ready = 1'b0; h_valid = 1'b1; h_addr = 24'h40; h_data = 64'h5;
    @(posedge sys_clk);
    @(negedge sys_clk);
    h_valid = 1'b0; inj_arm = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_valid !== 1'b1 || inj_pending !== 1'b1) begin
      miscompares++; $display("FAIL mid_setup: got v=%b pend=%b expected 1/1", m_valid, inj_pending);
    end
    @(negedge sys_clk);
    inj_arm = 1'b0; sys_rst = 1'b1; h_valid = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (m_valid !== 1'b0 || word_count !== 32'd0 || inj_pending !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: got v=%b cnt=%0d pend=%b expected 0/0/0", m_valid, word_count, inj_pending);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0; h_valid = 1'b0;
  endtask

  task automatic test_saturate();
    logic [31:0] exp_cnt [3];
    exp_cnt[0] = 32'hFFFF_FFFF; exp_cnt[1] = 32'hFFFF_FFFF; exp_cnt[2] = 32'hFFFF_FFFF;
    do_reset();
    @(negedge sys_clk);
    force dut.word_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.word_count_r;
    vectors++;
    if (word_count !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL sat_preload: got %h expected fffffffe", word_count);
    end
    m_ready = 1'b1; h_valid = 1'b1; h_addr = 24'h50; h_data = 64'h7;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk); #1;
      vectors++;
      if (word_count !== exp_cnt[i]) begin
        miscompares++; $display("FAIL sat_count[%0d]: got %h expected %h", i, word_count, exp_cnt[i]);
      end
    end
    @(negedge sys_clk);
    h_valid = 1'b0;
    @(posedge sys_clk); #1;
    vectors++;
    if (word_count !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL sat_hold: got %h expected ffffffff", word_count);
    end
  endtask

  initial begin
    test_reset();
    test_host_only();
    test_round_robin();
    test_backpressure();
    test_inject();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
